// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a first-word-fall-through byte FIFO
// built around a dual-address RAM with a combinational read port.
`default_nettype none

module fifo_ctrl #(
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  output logic              o_w_en,
  output logic [AWIDTH-1:0] o_waddress,
  output logic [AWIDTH-1:0] o_raddress,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [AWIDTH:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [AWIDTH:0] C_AF_LEVEL = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] C_AE_LEVEL = (AWIDTH+1)'(AE_LEVEL);

  logic [AWIDTH:0] r_wptr;
  logic [AWIDTH:0] r_rptr;
  logic            r_overflow;
  logic            r_underflow;

  logic [AWIDTH:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign w_full  = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                   (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_count = r_wptr - r_rptr;

  // A pop at full frees the slot being written, so the push is still accepted.
  // Gating with reset and flush keeps the RAM untouched while the pointers are cleared.
  assign w_push_ok = i_reset_n & ~i_flush & i_push & (~w_full | i_pop);
  assign w_pop_ok  = i_pop & ~w_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      if (i_push && !w_push_ok) r_overflow  <= 1'b1;
      if (i_pop  && !w_pop_ok)  r_underflow <= 1'b1;
    end
  end

  assign o_w_en         = w_push_ok;
  assign o_waddress     = r_wptr[AWIDTH-1:0];
  assign o_raddress     = r_rptr[AWIDTH-1:0];
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_count >= C_AF_LEVEL);
  assign o_almost_empty = (w_count <= C_AE_LEVEL);
  assign o_count        = w_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

`default_nettype wire
